// File: rtl/decoder_3to8_hold.sv
// Registered 3-to-8 one-hot decoder; each accepted code holds z[a] for HOLD_CYCLES clocks.
// Latency: z is one-hot from the edge that accepts the code; done flags the final hold cycle.
// Backpressure: in_ready only in IDLE or on the final hold cycle, so back-to-back codes stay gapless.
module decoder_3to8_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] a,
    output logic [7:0] z,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       z_nxt;
    logic             busy_nxt;
    logic             last_cycle;
    logic             accept;

    // rst gating keeps the handshake and done quiet during reset
    assign last_cycle = (state == HOLD) && (cnt == '0);
    assign in_ready   = !rst && enable && ((state == IDLE) || last_cycle);
    assign done       = !rst && enable && last_cycle;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        z_nxt     = z;
        busy_nxt  = busy;
        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            z_nxt     = 8'h00;
            busy_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    z_nxt = 8'h00;
                    if (accept) begin
                        state_nxt = HOLD;
                        cnt_nxt   = CNT_LOAD;
                        z_nxt     = 8'b1 << a;
                        busy_nxt  = 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt_nxt = cnt - 1'b1;
                    end else if (accept) begin
                        cnt_nxt = CNT_LOAD;
                        z_nxt   = 8'b1 << a;
                    end else begin
                        state_nxt = IDLE;
                        z_nxt     = 8'h00;
                        busy_nxt  = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    z_nxt     = 8'h00;
                    busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            z     <= 8'h00;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            z     <= z_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule
